truth_table_sequencer: RTL and testbench

- Sequencer that drives a 3-input combinational logic function (a, b, c -> f) through all 8 input combinations in order.
- Samples f for each combination after a programmable settle time and assembles the 8-bit truth table.
- Compares the table against an expected mask and reports pass/fail and a mismatch count.
- Sits beside any lab-style 3-input function module as its stimulus/checker controller (board self-test, bench reuse).

---
 rtl/truth_table_pkg.sv | 20 ++
 rtl/settle_timer.sv | 27 ++
 rtl/truth_table_sequencer.sv | 125 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types and widths for the truth table sequencer
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  // Value loaded into the settle timer so that a vector is held for 'cycles' cycles
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter timing how long each input vector is held
module settle_timer
  import truth_table_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps a 3-input function, captures and checks its truth table
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_VECTORS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f_in,
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out,
  output logic [3:0] mismatch_count
);
  import truth_table_pkg::*;

  localparam int LAST_INDEX = NUM_VECTORS - 1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] index;
  logic [7:0]       expected_q;
  logic             timer_load;
  logic             timer_zero;
  logic [CNT_W-1:0] timer_val;
  logic             bit_miss;
  logic             last_vector;

  assign timer_val   = settle_load(SETTLE_CYCLES);
  assign bit_miss    = f_in ^ expected_q[index];
  assign last_vector = (index == IDX_W'(LAST_INDEX));

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and timer reload decisions
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_vector) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sweep datapath: latch request, step the vector index, capture and score each sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index          <= '0;
      expected_q     <= '0;
      table_out      <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            expected_q     <= expected;
            table_out      <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
            index          <= '0;
          end
        end
        SAMPLE: begin
          table_out[index] <= f_in;
          mismatch_count   <= mismatch_count + 4'(bit_miss);
          // Verdict includes this final sample so it is already valid during DONE
          if (last_vector) begin
            pass <= (mismatch_count == '0) && !bit_miss;
          end else begin
            index <= index + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign abc_out = index;
  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer at three settle times
module tb_truth_table_sequencer;

  localparam int NI = 3;
  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam int S2 = 15;

  typedef struct {
    int         start_edge;
    int         due_cycle;
    logic [7:0] tbl;
    int         mism;
    int         pass;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    expected = 8'h00;
  logic [NI-1:0] f_in;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [NI-1:0] pass;
  logic [2:0]    abc [NI];
  logic [7:0]    tbl [NI];
  logic [3:0]    mism [NI];

  int         fsel = 0;
  logic [7:0] rand_fn = 8'h00;
  logic       dly_mode = 1'b0;

  exp_t sb [NI][$];
  int   busy_until [NI] = '{-1, -1, -1};
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    case (i)
      0:       return S0;
      1:       return S1;
      default: return S2;
    endcase
  endfunction

  // Functions under test: a&b, a^b^c, a|c, or an arbitrary random table
  function automatic logic fn(input int sel, input logic [7:0] rt, input logic [2:0] v);
    case (sel)
      0:       return v[2] & v[1];
      1:       return v[2] ^ v[1] ^ v[0];
      2:       return v[2] | v[0];
      default: return rt[v];
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_stub
    logic fd = 1'b0;
    always @(posedge clk) fd <= fn(fsel, rand_fn, abc[g]);
    assign f_in[g] = dly_mode ? fd : fn(fsel, rand_fn, abc[g]);
  end

  truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_in[0]),
    .abc_out(abc[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .table_out(tbl[0]), .mismatch_count(mism[0])
  );
  truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_in[1]),
    .abc_out(abc[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .table_out(tbl[1]), .mismatch_count(mism[1])
  );
  truth_table_sequencer #(.SETTLE_CYCLES(S2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_in[2]),
    .abc_out(abc[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .table_out(tbl[2]), .mismatch_count(mism[2])
  );

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (edge %0d)", name, inst, act, exp, edge_n);
    end
  endtask

  // Reference model: a sweep is accepted when the unit is idle; its result follows from the function alone
  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        sb[i].delete();
        busy_until[i] = -1;
      end else if (start && edge_n > busy_until[i]) begin
        for (int v = 0; v < 8; v++) e.tbl[v] = fn(fsel, rand_fn, 3'(v));
        e.mism       = $countones(e.tbl ^ expected);
        e.pass       = (e.mism == 0) ? 1 : 0;
        e.start_edge = edge_n;
        e.due_cycle  = 1 + 8 * (settle_of(i) + 1);
        busy_until[i] = edge_n + 8 * (settle_of(i) + 1) + 1;
        sb[i].push_back(e);
      end
    end
  end

  // Monitor: compare every done pulse against the oldest expected sweep, and track the main unit's stepping
  always @(negedge clk) begin
    exp_t front;
    int   cyc;
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        if (sb[i].size() > 0) begin
          front = sb[i][0];
          cyc   = edge_n - front.start_edge + 1;
          if (done[i]) begin
            chk("done_cycle", i, cyc, front.due_cycle);
            chk("table_out", i, int'(tbl[i]), int'(front.tbl));
            chk("mismatch_count", i, int'(mism[i]), front.mism);
            chk("pass", i, int'(pass[i]), front.pass);
            if (i == 0) chk("busy_in_done", i, int'(busy[i]), 0);
            void'(sb[i].pop_front());
          end else if (cyc >= front.due_cycle) begin
            chk("done_missing", i, 0, 1);
            void'(sb[i].pop_front());
          end else if (i == 0 && cyc >= 1) begin
            chk("abc_out", i, int'(abc[i]), (cyc - 1) / (S0 + 1));
            chk("busy", i, int'(busy[i]), 1);
          end
        end else if (done[i]) begin
          chk("unexpected_done", i, 1, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && guard < 400) begin
      tick(1);
      guard++;
    end
    chk("pending_after_wait", -1, sb[0].size() + sb[1].size() + sb[2].size(), 0);
    tick(2);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_abc_out"}, i, int'(abc[i]), 0);
      chk({tag, "_busy"}, i, int'(busy[i]), 0);
      chk({tag, "_done"}, i, int'(done[i]), 0);
      chk({tag, "_pass"}, i, int'(pass[i]), 0);
      chk({tag, "_table_out"}, i, int'(tbl[i]), 0);
      chk({tag, "_mismatch_count"}, i, int'(mism[i]), 0);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(3);
    @(negedge clk);
    check_reset_values("reset");
    tick(1);
    reset = 1'b0;
    tick(2);

    // a&b against its exact table
    fsel = 0; expected = 8'hC0;
    pulse_start();
    wait_idle();

    // parity against its inverse: every bit differs
    fsel = 1; expected = 8'h69;
    pulse_start();
    wait_idle();

    // a|c matching, then back-to-back with start held and a one-bit-off expectation
    fsel = 2; expected = 8'hFA;
    start = 1'b1;
    tick(1);
    expected = 8'hFB;
    tick(29);
    start = 1'b0;
    wait_idle();

    // reset in cycle 10 of a sweep, then a clean sweep
    fsel = 0; expected = 8'hC0;
    pulse_start();
    tick(9);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    tick(2);
    reset = 1'b0;
    tick(2);
    fsel = 1; expected = 8'h96;
    pulse_start();
    wait_idle();

    // extra starts at cycles 5 and 12 plus expected churn are ignored mid-sweep
    fsel = 3; rand_fn = 8'($urandom); expected = rand_fn;
    pulse_start();
    tick(4);
    expected = ~expected;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expected = 8'($urandom);
    wait_idle();

    // f_in lagging abc_out by one cycle, then undelayed random sweeps
    for (int pass_n = 0; pass_n < 8; pass_n++) begin
      dly_mode = (pass_n < 4);
      fsel     = (pass_n < 4) ? 3 : int'($urandom_range(3));
      rand_fn  = 8'($urandom);
      case ($urandom_range(2))
        0:       expected = 8'($urandom);
        1:       expected = rand_fn ^ (8'h01 << $urandom_range(7));
        default: expected = rand_fn;
      endcase
      if (fsel != 3 && $urandom_range(1) == 1) begin
        for (int v = 0; v < 8; v++) expected[v] = fn(fsel, rand_fn, 3'(v));
      end
      pulse_start();
      wait_idle();
    end
    dly_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
